// File: rtl/simd_lane_accum_pkg.sv
// Shared definitions for the SIMD lane accumulator.
//   - state_e    : frame FSM state encoding
//   - DefDataW   : default lane input width
//   - DefAccW    : default per-lane accumulator width
//   - DefFrameLen: default number of valid beats per frame
//   - clog2()    : constant ceiling-log2 used for counter sizing and parameter checks
package simd_lane_accum_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StTotal = 2'd2,
      StDone  = 2'd3
   } state_e;

   localparam int unsigned DefDataW    = 10;
   localparam int unsigned DefAccW     = 14;
   localparam int unsigned DefFrameLen = 16;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      int unsigned rem;
      res = 0;
      rem = (value > 0) ? value - 1 : 0;
      while (rem > 0) begin
         res = res + 1;
         rem = rem >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/simd_lane_accum_acc.sv
// Single-lane clear/accumulate/capture register.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, overrides ce
//   ce      : clock enable; all registers hold when low
//   clr     : clear the running accumulator
//   add_en  : add din into the accumulator
//   capture : load sum with acc + din (the final beat of a frame)
//   din     : unsigned lane input
//   acc     : running accumulator
//   sum     : captured frame sum, held until the next capture
module simd_lane_acc
   import simd_lane_accum_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned ACC_W  = DefAccW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              clr,
   input  logic              add_en,
   input  logic              capture,
   input  logic [DATA_W-1:0] din,
   output logic [ACC_W-1:0]  acc,
   output logic [ACC_W-1:0]  sum
);

   logic [ACC_W-1:0] acc_next;

   assign acc_next = acc + ACC_W'(din);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         sum <= '0;
      end else if (ce) begin
         if (clr) begin
            acc <= '0;
         end else if (add_en) begin
            acc <= acc_next;
         end
         // Capture includes the current beat so the frame closes without an extra cycle.
         if (capture) begin
            sum <= acc_next;
         end
      end
   end

endmodule

// File: rtl/simd_lane_accum.sv
// Four-lane frame accumulator with ap_ctrl_hs-style control.
//   ap_clk, ap_rst, ap_ce          : clock, synchronous active-high reset, clock enable
//   ap_start/ap_ready/ap_done/ap_idle : block-level handshake
//   in_vld, in1..in4               : lane results from the upstream SIMD adder
//   sum1..sum4                     : per-lane frame sums (registered, held between frames)
//   sum_total                      : sum of sum1..sum4 (registered)
//   sum_ap_vld                     : output valid, identical to ap_done
module simd_lane_accum
   import simd_lane_accum_pkg::*;
#(
   parameter int unsigned DATA_W    = DefDataW,
   parameter int unsigned FRAME_LEN = DefFrameLen,
   parameter int unsigned ACC_W     = DefAccW
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              ap_ce,
   input  logic              ap_start,
   output logic              ap_ready,
   output logic              ap_done,
   output logic              ap_idle,
   input  logic              in_vld,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   input  logic [DATA_W-1:0] in4,
   output logic [ACC_W-1:0]  sum1,
   output logic [ACC_W-1:0]  sum2,
   output logic [ACC_W-1:0]  sum3,
   output logic [ACC_W-1:0]  sum4,
   output logic [ACC_W+1:0]  sum_total,
   output logic              sum_ap_vld
);

   localparam int unsigned CntW = clog2(FRAME_LEN);

   if (FRAME_LEN < 2) begin : g_frame_len_err
      $error("simd_lane_accum: FRAME_LEN must be >= 2");
   end
   if (ACC_W < DATA_W + clog2(FRAME_LEN)) begin : g_acc_w_err
      $error("simd_lane_accum: ACC_W too narrow for DATA_W and FRAME_LEN");
   end

   state_e            state;
   logic [CntW-1:0]   cnt;

   logic              lane_clr;
   logic              lane_add;
   logic              last_beat;

   logic [DATA_W-1:0] lane_din [4];
   logic [ACC_W-1:0]  lane_acc [4];
   logic [ACC_W-1:0]  lane_sum [4];

   assign lane_din[0] = in1;
   assign lane_din[1] = in2;
   assign lane_din[2] = in3;
   assign lane_din[3] = in4;

   assign lane_clr  = (state == StIdle) && ap_start;
   assign lane_add  = (state == StRun) && in_vld;
   assign last_beat = lane_add && (cnt == CntW'(FRAME_LEN - 1));

   for (genvar i = 0; i < 4; i++) begin : g_lane
      simd_lane_acc #(
         .DATA_W (DATA_W),
         .ACC_W  (ACC_W)
      ) u_lane (
         .clk     (ap_clk),
         .rst     (ap_rst),
         .ce      (ap_ce),
         .clr     (lane_clr),
         .add_en  (lane_add),
         .capture (last_beat),
         .din     (lane_din[i]),
         .acc     (lane_acc[i]),
         .sum     (lane_sum[i])
      );
   end

   // The running accumulators are only observed inside the lanes.
   logic unused_lane_acc;
   assign unused_lane_acc = ^{lane_acc[0], lane_acc[1], lane_acc[2], lane_acc[3]};

   assign sum1 = lane_sum[0];
   assign sum2 = lane_sum[1];
   assign sum3 = lane_sum[2];
   assign sum4 = lane_sum[3];

   assign ap_idle    = (state == StIdle);
   assign ap_ready   = (state == StIdle) && ap_start && ap_ce;
   assign sum_ap_vld = ap_done;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state     <= StIdle;
         cnt       <= '0;
         sum_total <= '0;
         ap_done   <= 1'b0;
      end else if (ap_ce) begin
         unique case (state)
            StIdle: begin
               if (ap_start) begin
                  cnt   <= '0;
                  state <= StRun;
               end
            end
            StRun: begin
               if (in_vld) begin
                  if (last_beat) begin
                     cnt   <= '0;
                     state <= StTotal;
                  end else begin
                     cnt <= cnt + CntW'(1);
                  end
               end
            end
            StTotal: begin
               // Lane sums were captured on the final beat and are stable here.
               sum_total <= (ACC_W+2)'(sum1) + (ACC_W+2)'(sum2)
                          + (ACC_W+2)'(sum3) + (ACC_W+2)'(sum4);
               ap_done   <= 1'b1;
               state     <= StDone;
            end
            StDone: begin
               ap_done <= 1'b0;
               state   <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_simd_lane_accum.sv
module tb_simd_lane_accum;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        ap_ce = 1'b1;
   logic        ap_start = 1'b0;
   logic        ap_ready;
   logic        ap_done;
   logic        ap_idle;
   logic        in_vld = 1'b0;
   logic [9:0]  in1 = '0, in2 = '0, in3 = '0, in4 = '0;
   logic [13:0] sum1, sum2, sum3, sum4;
   logic [15:0] sum_total;
   logic        sum_ap_vld;

   int checks = 0;
   int failures = 0;
   int ready_cnt = 0;
   int ready_base;

   simd_lane_accum dut (
      .ap_clk     (ap_clk),
      .ap_rst     (ap_rst),
      .ap_ce      (ap_ce),
      .ap_start   (ap_start),
      .ap_ready   (ap_ready),
      .ap_done    (ap_done),
      .ap_idle    (ap_idle),
      .in_vld     (in_vld),
      .in1        (in1),
      .in2        (in2),
      .in3        (in3),
      .in4        (in4),
      .sum1       (sum1),
      .sum2       (sum2),
      .sum3       (sum3),
      .sum4       (sum4),
      .sum_total  (sum_total),
      .sum_ap_vld (sum_ap_vld)
   );

   always #5 ap_clk = ~ap_clk;

   always @(posedge ap_clk) begin
      if (ap_ready) ready_cnt <= ready_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs and samples sit 1 time unit after the edge.
   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic beat(input int a, input int b, input int c, input int d);
      in_vld = 1'b1;
      in1 = 10'(a); in2 = 10'(b); in3 = 10'(c); in4 = 10'(d);
      step();
      in_vld = 1'b0;
   endtask

   // Stall cycle with junk lane values that must not be accumulated.
   task automatic stall();
      in_vld = 1'b0;
      in1 = 10'd1023; in2 = 10'd1023; in3 = 10'd1023; in4 = 10'd1023;
      step();
   endtask

   task automatic start_frame(input string tag);
      ap_start = 1'b1;
      #1;
      check({tag, "_ready"}, ap_ready, 1);
      step();
      ap_start = 1'b0;
   endtask

   task automatic check_sums(input string tag, input int e1, input int e2, input int e3,
                             input int e4);
      check({tag, "_sum1"}, sum1, e1);
      check({tag, "_sum2"}, sum2, e2);
      check({tag, "_sum3"}, sum3, e3);
      check({tag, "_sum4"}, sum4, e4);
   endtask

   // Called right after the final beat edge: TOTAL cycle, then DONE, then IDLE.
   task automatic end_frame(input string tag, input int e1, input int e2, input int e3,
                            input int e4, input int et);
      check({tag, "_total_done"}, ap_done, 0);
      check_sums(tag, e1, e2, e3, e4);
      step();
      check({tag, "_done"}, ap_done, 1);
      check({tag, "_vld"}, sum_ap_vld, 1);
      check({tag, "_total"}, sum_total, et);
      step();
      check({tag, "_done_fall"}, ap_done, 0);
      check({tag, "_idle"}, ap_idle, 1);
   endtask

   initial begin
      // 1. Reset then idle
      ap_rst = 1'b1;
      repeat (3) step();
      ap_rst = 1'b0;
      step();
      check("rst_idle", ap_idle, 1);
      check("rst_done", ap_done, 0);
      check("rst_vld", sum_ap_vld, 0);
      check("rst_ready", ap_ready, 0);
      check_sums("rst", 0, 0, 0, 0);
      check("rst_total", sum_total, 0);

      // 2. Full-scale frame; in_vld on the start edge must not count
      in_vld = 1'b1;
      in1 = 10'd1023; in2 = 10'd1023; in3 = 10'd1023; in4 = 10'd1023;
      start_frame("full");
      check("full_run_idle", ap_idle, 0);
      for (int k = 0; k < 16; k++) beat(1023, 1023, 1023, 1023);
      end_frame("full", 16368, 16368, 16368, 16368, 65472);

      // 3. Alternating stalls, lane i adds k + i - 1
      start_frame("stall");
      for (int k = 0; k < 16; k++) begin
         beat(k, k + 1, k + 2, k + 3);
         if (k != 15) stall();
      end
      end_frame("stall", 120, 136, 152, 168, 576);

      // 4. ap_ce gating mid-RUN and during DONE, lane i adds 2k + i - 1
      start_frame("ce");
      for (int k = 0; k < 8; k++) beat(2 * k, 2 * k + 1, 2 * k + 2, 2 * k + 3);
      ap_ce = 1'b0;
      in_vld = 1'b1;
      in1 = 10'd1023; in2 = 10'd1023; in3 = 10'd1023; in4 = 10'd1023;
      repeat (5) step();
      ap_ce = 1'b1;
      in_vld = 1'b0;
      for (int k = 8; k < 16; k++) beat(2 * k, 2 * k + 1, 2 * k + 2, 2 * k + 3);
      check("ce_total_done", ap_done, 0);
      check_sums("ce", 240, 256, 272, 288);
      step();
      check("ce_done", ap_done, 1);
      check("ce_total", sum_total, 1056);
      ap_ce = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("ce_done_hold", ap_done, 1);
      end
      ap_ce = 1'b1;
      step();
      check("ce_done_fall", ap_done, 0);
      check("ce_idle", ap_idle, 1);

      // 5. Reset mid-frame aborts
      start_frame("abort");
      for (int k = 0; k < 7; k++) beat(5, 5, 5, 5);
      ap_rst = 1'b1;
      step();
      ap_rst = 1'b0;
      check("abort_idle", ap_idle, 1);
      check_sums("abort", 0, 0, 0, 0);
      check("abort_total", sum_total, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("abort_no_done", ap_done, 0);
      end
      start_frame("ones");
      for (int k = 0; k < 16; k++) beat(1, 1, 1, 1);
      end_frame("ones", 16, 16, 16, 16, 64);

      // 6. Back-to-back frames with ap_start held high
      ready_base = ready_cnt;
      ap_start = 1'b1;
      #1;
      check("b2b_ready1", ap_ready, 1);
      step();
      for (int k = 0; k < 16; k++) begin
         check("b2b_run_ready", ap_ready, 0);
         beat(3, 3, 3, 3);
      end
      check_sums("b2b_f1", 48, 48, 48, 48);
      check("b2b_f1_total_hold", sum_total, 64);
      check("b2b_total_ready", ap_ready, 0);
      step();
      check("b2b_f1_done", ap_done, 1);
      check("b2b_done_ready", ap_ready, 0);
      check("b2b_f1_total", sum_total, 192);
      step();
      check("b2b_ready2", ap_ready, 1);
      step();
      for (int k = 0; k < 15; k++) beat(2, 2, 2, 2);
      check_sums("b2b_f2_hold", 48, 48, 48, 48);
      beat(2, 2, 2, 2);
      check_sums("b2b_f2", 32, 32, 32, 32);
      check("b2b_f2_total_hold", sum_total, 192);
      step();
      ap_start = 1'b0;
      check("b2b_f2_done", ap_done, 1);
      check("b2b_f2_total", sum_total, 128);
      step();
      check("b2b_f2_done_fall", ap_done, 0);
      check("b2b_ready_pulses", ready_cnt - ready_base, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/simd_lane_accum.md
Name: simd_lane_accum

Overview:
- Downstream stage of the 4-lane SIMD adder block.
- Consumes the four 10-bit lane results and their valid strobe, and accumulates each lane over a frame of FRAME_LEN valid beats.
- Reports the per-lane sums and a cross-lane total under an ap_ctrl_hs-style handshake (ap_start/ap_ready/ap_done/ap_idle) with ap_ce clock-enable gating, matching the upstream block's control style.

Parameters:
- DATA_W, 10: width of each incoming lane value (unsigned).
- FRAME_LEN, 16: number of valid beats per frame; must be >= 2.
- ACC_W, 14: per-lane accumulator width. Elaboration error if ACC_W < DATA_W + clog2(FRAME_LEN).

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- ap_ce  in  1  clock enable; when low, every register holds its value.
- ap_start  in  1  request to begin a frame.
- ap_ready  out  1  frame start accepted this cycle.
- ap_done  out  1  frame results valid.
- ap_idle  out  1  block is idle, waiting for ap_start.
- in_vld  in  1  lane inputs valid; driven from the upstream z*_ap_vld.
- in1..in4  in  DATA_W each  lane values; driven from the upstream z1..z4.
- sum1..sum4  out  ACC_W each  per-lane frame sums, registered.
- sum_total  out  ACC_W+2  sum of sum1..sum4, registered.
- sum_ap_vld  out  1  equals ap_done.

Behaviour:
- Reset (ap_rst=1 at a clock edge, regardless of ap_ce):
  - state=IDLE; accumulators, beat counter, sum1..4 and sum_total all 0.
  - ap_done=0, sum_ap_vld=0. ap_idle=1 from the first cycle after reset.
- Reset mid-frame aborts the frame: no ap_done is produced and the outputs read 0.
- All state updates below occur only on edges where ap_ce=1. With ap_ce=0 the state, counters, accumulators, outputs and ap_done all hold; a held ap_done stays high.
- FSM states are IDLE, RUN, TOTAL and DONE.
- IDLE:
  - ap_idle=1.
  - ap_ready = ap_start & ap_ce (combinational, from state).
  - On ap_start: clear the four accumulators, set cnt=0, go to RUN.
  - in_vld is ignored in IDLE.
- RUN:
  - ap_idle=0.
  - Each cycle with in_vld=1: acc_i <= acc_i + in_i (zero-extended), cnt <= cnt+1.
  - Cycles with in_vld=0 are stalls: nothing changes.
  - When in_vld=1 and cnt==FRAME_LEN-1: sum_i <= acc_i + in_i, then go to TOTAL. That beat counts as the final beat.
  - ap_start is ignored in RUN.
- TOTAL (1 cycle): sum_total <= sum1+sum2+sum3+sum4, computed at width ACC_W+2; then go to DONE.
- DONE (1 ce-cycle):
  - ap_done=1 and sum_ap_vld=1; then go to IDLE.
  - ap_start in DONE is not accepted; it is accepted on the following IDLE cycle.
- Latency: ap_done rises 2 ce-cycles after the final accepted in_vld beat.
- Minimum frame period: FRAME_LEN+3 cycles, assuming no stalls and ap_start held high.
- Hold rule: sum1..4 and sum_total hold their values until the next frame's final beat or TOTAL cycle overwrites them. They are not cleared at ap_start.
- Arithmetic is unsigned, and the ACC_W rule guarantees no overflow. There is no saturation or wrap logic.
- Boundary cases:
  - in_vld on the same edge that ap_start is accepted is not counted; counting starts in RUN.
  - in_vld=1 continuously for exactly FRAME_LEN cycles completes the frame.

Decomposition:
- Shared package/header holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, TOTAL=2'd2, DONE=2'd3);
  - the DATA_W/ACC_W defaults;
  - a clog2 constant function.
- One natural sub-module, simd_lane_acc, instantiated four times:
  - function: a single-lane clear/accumulate/capture register with ce gating;
  - ports: clk, rst, ce, clr, add_en, capture, din, acc, sum.

Test Plan:
1. Reset, then idle: ap_rst for 3 cycles, ap_start=0 -> ap_idle=1, ap_done=0, all sums 0, ap_ready=0.
2. Full-scale frame: ap_start, then in1..in4=1023 for 16 consecutive beats -> sum1..4=16368, sum_total=65472, ap_done high for exactly 1 cycle, 2 cycles after the 16th beat.
3. Stalls: in_vld toggled 1,0,1,0 with in_i = beat index k (0..15), lane i adding i-1 -> sum1=120, sum2=136, sum3=152, sum4=168, sum_total=576, ap_done 2 cycles after the 16th valid beat.
4. ap_ce=0 for 5 cycles mid-RUN and again during DONE -> no beats counted while ap_ce=0, ap_done stays high until ap_ce returns, results identical to the ungated run.
5. Reset mid-frame: ap_rst after 7 beats -> no ap_done, sums 0; a following frame of in_i=1 gives sum_i=16, sum_total=64.
6. Back-to-back frames: ap_start held high -> ap_ready pulses once per frame, ap_start ignored during RUN and DONE, frame 2 results (in_i=2 -> 32 each, sum_total 128) replace frame 1 results only at frame 2's final beat and TOTAL cycle.
